// File: rtl/clock_div_ctrl.sv
// Rollover-driven clock divider with run/stop sequencing and a valid/ready
// divisor-update port; divisor changes only land on rollover boundaries.
module clock_div_ctrl #(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_div_valid,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_div_ready,
    output logic             o_div_err,
    output logic [DIV_W-1:0] o_count,
    output logic             o_roll_over,
    output logic             o_clk_div,
    output logic             o_running
);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PENDING = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] k_q, k_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_q, pend_d;
    logic [DIV_W-1:0] count_d;
    logic             roll_d, clk_div_d, ready_d, err_d, running_d;
    logic             accept, div_zero, counting, at_top;

    assign accept   = i_div_valid & o_div_ready;
    assign div_zero = (i_div == '0);
    assign counting = (state_q != ST_STOPPED);
    assign at_top   = counting && (o_count == (k_q - DIV_W'(1)));

    // Next-state, counter and handshake logic
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        pend_d     = pend_q;
        pend_div_d = pend_div_q;
        count_d    = o_count;
        roll_d     = 1'b0;
        clk_div_d  = o_clk_div;
        err_d      = accept & div_zero;

        if (counting) begin
            if (at_top) begin
                count_d   = '0;
                roll_d    = 1'b1;
                clk_div_d = ~o_clk_div;
            end else begin
                count_d = o_count + DIV_W'(1);
            end
        end

        // A queued divisor lands on the rollover edge, before any new accept
        if (at_top && pend_q) begin
            k_d    = pend_div_q;
            pend_d = 1'b0;
        end

        if (accept && !div_zero) begin
            if (state_q == ST_STOPPED) begin
                k_d = i_div;
            end else begin
                pend_d     = 1'b1;
                pend_div_d = i_div;
            end
        end

        case (state_q)
            ST_STOPPED: begin
                count_d   = '0;
                clk_div_d = 1'b0;
                if (i_enable) state_d = ST_RUNNING;
            end
            ST_RUNNING, ST_PENDING: begin
                if (!i_enable)   state_d = ST_DRAIN;
                else if (pend_d) state_d = ST_PENDING;
                else             state_d = ST_RUNNING;
            end
            ST_DRAIN: begin
                if (i_enable) begin
                    state_d = pend_d ? ST_PENDING : ST_RUNNING;
                end else if (at_top && o_clk_div) begin
                    // Falling rollover: park low and flush any queued divisor
                    state_d   = ST_STOPPED;
                    count_d   = '0;
                    clk_div_d = 1'b0;
                    if (pend_d) begin
                        k_d    = pend_div_d;
                        pend_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_STOPPED;
        endcase

        ready_d   = (state_d == ST_STOPPED) || (state_d == ST_RUNNING) ||
                    ((state_d == ST_DRAIN) && !pend_d);
        running_d = (state_d != ST_STOPPED);
    end

    // State and output registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_STOPPED;
            k_q         <= DIV_W'(DEFAULT_DIV);
            pend_q      <= 1'b0;
            pend_div_q  <= '0;
            o_count     <= '0;
            o_roll_over <= 1'b0;
            o_clk_div   <= 1'b0;
            o_div_err   <= 1'b0;
            o_running   <= 1'b0;
            o_div_ready <= 1'b1;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            pend_q      <= pend_d;
            pend_div_q  <= pend_div_d;
            o_count     <= count_d;
            o_roll_over <= roll_d;
            o_clk_div   <= clk_div_d;
            o_div_err   <= err_d;
            o_running   <= running_d;
            o_div_ready <= ready_d;
        end
    end

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Directed bench for clock_div_ctrl: stimulus pushes expected rollovers and
// error pulses into queues, a negedge monitor pops and compares them.
module tb_clock_div_ctrl;

    localparam int unsigned DIV_W = 8;

    typedef struct {
        logic clk_div;
        int   k;
    } roll_exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             div_valid;
    logic [DIV_W-1:0] div;
    logic             div_ready, div_err, roll_over, clk_div, running;
    logic [DIV_W-1:0] count;

    roll_exp_t        exp_q[$];
    roll_exp_t        mon_e;
    int               err_exp = 0;
    int               n_checks = 0;
    int               n_fail = 0;
    int               edge_no = 0;
    logic [DIV_W-1:0] prev_count = '0;

    clock_div_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(3)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_enable    (enable),
        .i_div_valid (div_valid),
        .i_div       (div),
        .o_div_ready (div_ready),
        .o_div_err   (div_err),
        .o_count     (count),
        .o_roll_over (roll_over),
        .o_clk_div   (clk_div),
        .o_running   (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_roll(input logic c, input int k);
        roll_exp_t e;
        e.clk_div = c;
        e.k       = k;
        exp_q.push_back(e);
    endtask

    // Advance to #1 after system edge n (edge 0 is the reset-release edge)
    task automatic goto(input int n);
        while (edge_no < n) begin
            @(posedge clk);
            edge_no++;
        end
        #1;
    endtask

    // Monitor: each rollover must match the next queued entry
    always @(negedge clk) begin
        if (rst) begin
            prev_count = '0;
        end else begin
            if (roll_over) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rollover: got roll at count %0d, required none", prev_count);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("roll_clk_div", int'(clk_div), int'(mon_e.clk_div));
                    check("roll_half_period", int'(prev_count) + 1, mon_e.k);
                end
            end
            if (div_err) begin
                n_checks++;
                if (err_exp > 0) begin
                    err_exp--;
                end else begin
                    n_fail++;
                    $display("FAIL unexpected_div_err: got pulse, required none");
                end
            end
            prev_count = count;
        end
    end

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        div_valid = 1'b0;
        div       = '0;
        #2;
        check("rst_count", int'(count), 0);
        check("rst_clk_div", int'(clk_div), 0);
        check("rst_roll", int'(roll_over), 0);
        check("rst_running", int'(running), 0);
        check("rst_err", int'(div_err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rel_ready", int'(div_ready), 1);

        // Default k=3 run
        push_roll(1'b1, 3); push_roll(1'b0, 3); push_roll(1'b1, 3);
        push_roll(1'b0, 3); push_roll(1'b1, 3);
        push_roll(1'b0, 5); push_roll(1'b1, 5);
        push_roll(1'b0, 3); push_roll(1'b1, 3); push_roll(1'b0, 3);
        enable = 1'b1;
        goto(1); check("c_e1", int'(count), 0); check("ck_e1", int'(clk_div), 0);
        check("run_e1", int'(running), 1);
        goto(2); check("c_e2", int'(count), 1); check("ck_e2", int'(clk_div), 0);
        goto(3); check("c_e3", int'(count), 2); check("ck_e3", int'(clk_div), 0);
        goto(4); check("c_e4", int'(count), 0); check("ck_e4", int'(clk_div), 1);

        // Mid-count update to 5, lands on the next rollover
        goto(14); div_valid = 1'b1; div = 8'd5;
        goto(15); div_valid = 1'b0;
        check("pend_ready", int'(div_ready), 0);
        check("pend_count", int'(count), 2);
        goto(16); check("applied_ready", int'(div_ready), 1);
        goto(21); div_valid = 1'b1; div = 8'd3;
        goto(22); div_valid = 1'b0;

        // Stop requested in low phase: drains through high phase
        goto(30); enable = 1'b0;
        goto(34); check("drain_running", int'(running), 1);
        goto(35); check("stop_running", int'(running), 0);
        check("stop_count", int'(count), 0); check("stop_clk", int'(clk_div), 0);
        goto(36); check("stopped_clk", int'(clk_div), 0);

        // Zero divisor discarded, k stays 3
        div_valid = 1'b1; div = 8'd0; err_exp++;
        goto(37); div_valid = 1'b0;
        check("zero_err", int'(div_err), 1);
        check("zero_ready", int'(div_ready), 1);
        goto(38); check("zero_err_clr", int'(div_err), 0);
        push_roll(1'b1, 3); push_roll(1'b0, 3);
        enable = 1'b1;
        goto(42); enable = 1'b0;

        // k=1: toggle every cycle
        goto(45); div_valid = 1'b1; div = 8'd1;
        goto(46); div_valid = 1'b0; enable = 1'b1;
        for (int i = 0; i < 8; i++) push_roll(((i % 2) == 0) ? 1'b1 : 1'b0, 1);
        push_roll(1'b1, 3);
        goto(53); div_valid = 1'b1; div = 8'd3;
        goto(54); div_valid = 1'b0;

        // Async reset with clk high, count 2, update pending
        goto(59); div_valid = 1'b1; div = 8'd7;
        goto(60); div_valid = 1'b0;
        check("pre_rst_clk", int'(clk_div), 1);
        check("pre_rst_count", int'(count), 2);
        check("pre_rst_ready", int'(div_ready), 0);
        #2; rst = 1'b1; enable = 1'b0;
        #1;
        check("async_count", int'(count), 0);
        check("async_clk", int'(clk_div), 0);
        check("async_running", int'(running), 0);
        check("async_roll", int'(roll_over), 0);
        goto(61); rst = 1'b0;
        #1; check("rel2_ready", int'(div_ready), 1);
        check("rel2_count", int'(count), 0);
        push_roll(1'b1, 3); push_roll(1'b0, 3); push_roll(1'b1, 3);
        push_roll(1'b0, 3);
        push_roll(1'b1, 4); push_roll(1'b0, 4); push_roll(1'b1, 4);
        push_roll(1'b0, 4);
        goto(62); enable = 1'b1;

        // Update and stop on the same edge, high phase
        goto(72); div_valid = 1'b1; div = 8'd4; enable = 1'b0;
        goto(73); div_valid = 1'b0;
        check("drain_pend_ready", int'(div_ready), 0);
        check("drain_pend_running", int'(running), 1);
        goto(75); check("stop2_running", int'(running), 0);
        check("stop2_clk", int'(clk_div), 0);
        enable = 1'b1;
        goto(88); enable = 1'b0;

        goto(95);
        check("final_running", int'(running), 0);
        check("rollovers_left", exp_q.size(), 0);
        check("errs_left", err_exp, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
